rr_write_arbiter: RTL and testbench

Round-robin arbiter that shares a single SIZE-bit destination register write port among NUM_REQ requesters. It sits in front of the shared enable-loaded register and grants exclusive multi-beat ownership to one requester at a time. It drives that register's Enable and D inputs from the owning requester. Priority rotates after each completed grant, so no requester starves.

---
 rtl/rr_write_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter granting exclusive multi-beat ownership of one shared register write port.
// Optional grant-length limit enabled by defining ARB_TIMEOUT_EN.
module rr_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SIZE     = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         iRequest,
    input  logic [NUM_REQ-1:0]         iLast,
    input  logic [NUM_REQ*SIZE-1:0]    iData,
    output logic [NUM_REQ-1:0]         oGrant,
    output logic [$clog2(NUM_REQ)-1:0] oOwner,
    output logic                       oWriteEnable,
    output logic [SIZE-1:0]            oWriteData,
    output logic                       oBusy,
    output logic                       oTimeout
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] grant, grant_next;
    logic [IW-1:0]      owner, owner_next;
    logic [IW-1:0]      ptr, ptr_next;
    logic [IW-1:0]      ptr_inc;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               owner_req, owner_last;
    logic               forced;
    logic               done;

    if (NUM_REQ < 2 || NUM_REQ > 8 || SIZE < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_write_arbiter: illegal parameter value");
    end

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned cand;
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!pick_valid && iRequest[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    assign owner_req  = iRequest[owner];
    assign owner_last = iLast[owner];
    assign ptr_inc    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold;
    logic          timeout;

    // A completing or abandoning last beat takes precedence over the limit.
    assign forced = (state == GRANT) && (hold == HW'(MAX_HOLD - 1)) && owner_req && !owner_last;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            hold    <= (state == GRANT) ? hold + 1'b1 : '0;
            timeout <= forced;
        end
    end

    assign oTimeout = timeout;
`else
    assign forced   = 1'b0;
    assign oTimeout = 1'b0;
`endif

    assign done = !owner_req || owner_last || forced;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            owner <= owner_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        owner_next = owner;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                    grant_next = NUM_REQ'(1) << pick_idx;
                    owner_next = pick_idx;
                end
            end
            GRANT: begin
                if (done) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = ptr_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign oGrant       = grant;
    assign oOwner       = owner;
    assign oBusy        = (state == GRANT);
    assign oWriteEnable = (state == GRANT) && owner_req;
    assign oWriteData   = iData[32'(owner) * SIZE +: SIZE];

endmodule

// File: tb/tb_rr_write_arbiter.sv
// Directed self-checking bench for rr_write_arbiter (NUM_REQ=4, SIZE=8, MAX_HOLD=4).
module tb_rr_write_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  iRequest;
    logic [3:0]  iLast;
    logic [31:0] iData;
    logic [3:0]  oGrant;
    logic [1:0]  oOwner;
    logic        oWriteEnable;
    logic [7:0]  oWriteData;
    logic        oBusy;
    logic        oTimeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_write_arbiter #(.NUM_REQ(4), .SIZE(8), .MAX_HOLD(4)) dut (
        .Clock(Clock), .Reset(Reset), .iRequest(iRequest), .iLast(iLast), .iData(iData),
        .oGrant(oGrant), .oOwner(oOwner), .oWriteEnable(oWriteEnable), .oWriteData(oWriteData),
        .oBusy(oBusy), .oTimeout(oTimeout)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        iRequest = 4'b0000;
        iLast    = 4'b0000;
        iData    = 32'h33_A5_22_11;
        #1 Reset = 1'b0;
        #1;
        n_checks++;
        if ({oGrant, oOwner, oBusy, oWriteEnable, oTimeout} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b owner=%0d busy=%b we=%b to=%b, expected all zero",
                     oGrant, oOwner, oBusy, oWriteEnable, oTimeout);
        end
        iRequest = 4'b1111;
        tick();
        n_checks++;
        if ({oGrant, oBusy, oWriteEnable} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold: grant=%b busy=%b we=%b, expected 0000/0/0", oGrant, oBusy, oWriteEnable);
        end
        iRequest = 4'b0000;
        Reset    = 1'b1;
        #1;
        n_checks++;
        if ({oGrant, oBusy, oWriteEnable} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_release: grant=%b busy=%b we=%b, expected 0000/0/0", oGrant, oBusy, oWriteEnable);
        end
    endtask

    task automatic test_single();
        iRequest = 4'b0100;
        iLast    = 4'b0000;
        #1;
        n_checks++;
        if (oGrant !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_pre: grant=%b, expected 0000", oGrant);
        end
        for (int b = 1; b <= 3; b++) begin
            tick();
            if (b == 3) iLast = 4'b0100;
            #1;
            n_checks++;
            if ({oGrant, oOwner, oBusy, oWriteEnable, oWriteData} !== {4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5}) begin
                n_fail++;
                $display("FAIL single_beat%0d: grant=%b owner=%0d busy=%b we=%b data=%h, expected 0100/2/1/1/a5",
                         b, oGrant, oOwner, oBusy, oWriteEnable, oWriteData);
            end
        end
        tick();
        iRequest = 4'b1111;
        iLast    = 4'b1111;
        #1;
        n_checks++;
        if ({oGrant, oOwner, oBusy, oWriteEnable} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_release: grant=%b owner=%0d busy=%b we=%b, expected 0000/2/0/0",
                     oGrant, oOwner, oBusy, oWriteEnable);
        end
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner, oWriteEnable, oWriteData} !== {4'b1000, 2'd3, 1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL single_ptr3: grant=%b owner=%0d we=%b data=%h, expected 1000/3/1/33",
                     oGrant, oOwner, oWriteEnable, oWriteData);
        end
    endtask

    task automatic test_all_requesting();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            n_checks++;
            if ({oGrant, oBusy} !== 5'b0) begin
                n_fail++;
                $display("FAIL all_gap%0d: grant=%b busy=%b, expected 0000/0", k, oGrant, oBusy);
            end
            tick();
            #1;
            exp_g = 4'b0001 << (k % 4);
            exp_d = iData[(k % 4) * 8 +: 8];
            n_checks++;
            if ({oGrant, oOwner, oWriteEnable, oWriteData} !== {exp_g, 2'(k % 4), 1'b1, exp_d}) begin
                n_fail++;
                $display("FAIL all_grant%0d: grant=%b owner=%0d we=%b data=%h, expected %b/%0d/1/%h",
                         k, oGrant, oOwner, oWriteEnable, oWriteData, exp_g, k % 4, exp_d);
            end
        end
        iRequest = 4'b0000;
        #1;
        n_checks++;
        if ({oGrant, oBusy, oWriteEnable} !== {4'b0001, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL all_abandon: grant=%b busy=%b we=%b, expected 0001/1/0", oGrant, oBusy, oWriteEnable);
        end
        tick();
    endtask

    task automatic test_wrap();
        iRequest = 4'b0100;
        iLast    = 4'b0100;
        tick();
        iRequest = 4'b0111;
        iLast    = 4'b0111;
        #1;
        n_checks++;
        if ({oGrant, oWriteEnable} !== 5'b0100_1) begin
            n_fail++;
            $display("FAIL wrap_setup: grant=%b we=%b, expected 0100/1", oGrant, oWriteEnable);
        end
        tick();
        iRequest = 4'b0011;
        iLast    = 4'b0011;
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner, oWriteEnable, oWriteData} !== {4'b0001, 2'd0, 1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL wrap_to0: grant=%b owner=%0d we=%b data=%h, expected 0001/0/1/11",
                     oGrant, oOwner, oWriteEnable, oWriteData);
        end
        tick();
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner} !== {4'b0010, 2'd1}) begin
            n_fail++;
            $display("FAIL wrap_next1: grant=%b owner=%0d, expected 0010/1", oGrant, oOwner);
        end
        iRequest = 4'b0000;
        iLast    = 4'b0000;
        tick();
    endtask

    task automatic test_abandon();
        iRequest = 4'b0010;
        tick();
        #1;
        n_checks++;
        if ({oGrant, oWriteEnable, oWriteData} !== {4'b0010, 1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL abandon_beat1: grant=%b we=%b data=%h, expected 0010/1/22", oGrant, oWriteEnable, oWriteData);
        end
        tick();
        iRequest = 4'b0101;
        #1;
        n_checks++;
        if ({oGrant, oBusy, oWriteEnable} !== {4'b0010, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abandon_beat2: grant=%b busy=%b we=%b, expected 0010/1/0", oGrant, oBusy, oWriteEnable);
        end
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner, oBusy} !== {4'b0000, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL abandon_release: grant=%b owner=%0d busy=%b, expected 0000/1/0", oGrant, oOwner, oBusy);
        end
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner} !== {4'b0100, 2'd2}) begin
            n_fail++;
            $display("FAIL abandon_ptr2: grant=%b owner=%0d, expected 0100/2", oGrant, oOwner);
        end
        iRequest = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        iRequest = 4'b0010;
        tick();
        tick();
        #1;
        n_checks++;
        if ({oGrant, oWriteEnable} !== 5'b0010_1) begin
            n_fail++;
            $display("FAIL midrst_beat2: grant=%b we=%b, expected 0010/1", oGrant, oWriteEnable);
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({oGrant, oOwner, oBusy, oWriteEnable} !== 8'b0) begin
            n_fail++;
            $display("FAIL midrst_async: grant=%b owner=%0d busy=%b we=%b, expected 0000/0/0/0",
                     oGrant, oOwner, oBusy, oWriteEnable);
        end
        iRequest = 4'b1111;
        tick();
        Reset = 1'b1;
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner} !== {4'b0001, 2'd0}) begin
            n_fail++;
            $display("FAIL midrst_ptr0: grant=%b owner=%0d, expected 0001/0", oGrant, oOwner);
        end
        iRequest = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        iRequest = 4'b0010;
        iLast    = 4'b0000;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int b = 1; b <= 4; b++) begin
            if (b == 4) iRequest = 4'b0110;
            #1;
            n_checks++;
            if ({oGrant, oWriteEnable, oTimeout} !== {4'b0010, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_beat%0d: grant=%b we=%b to=%b, expected 0010/1/0", b, oGrant, oWriteEnable, oTimeout);
            end
            tick();
        end
        #1;
        n_checks++;
        if ({oGrant, oBusy, oTimeout} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_release: grant=%b busy=%b to=%b, expected 0000/0/1", oGrant, oBusy, oTimeout);
        end
        tick();
        #1;
        n_checks++;
        if ({oGrant, oOwner, oTimeout} !== {4'b0100, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_next: grant=%b owner=%0d to=%b, expected 0100/2/0", oGrant, oOwner, oTimeout);
        end
`else
        for (int b = 1; b <= 6; b++) begin
            #1;
            n_checks++;
            if ({oGrant, oWriteEnable, oTimeout} !== {4'b0010, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL unbounded_beat%0d: grant=%b we=%b to=%b, expected 0010/1/0", b, oGrant, oWriteEnable, oTimeout);
            end
            tick();
        end
`endif
        iRequest = 4'b0000;
        tick();
        #1;
        n_checks++;
        if ({oGrant, oBusy, oTimeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: grant=%b busy=%b to=%b, expected 0000/0/0", oGrant, oBusy, oTimeout);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_wrap();
        test_abandon();
        test_reset_mid_grant();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
